// File: rtl/pck_proc_pkg.sv
// rtl/pck_proc_pkg.sv - shared constants and types for the packet FIFO
package pck_proc_pkg;

  localparam int PCK_DEPTH  = 8192;
  localparam int PCK_ADDR_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } mem_word_t;

endpackage

// File: rtl/pck_proc_mem.sv
// rtl/pck_proc_mem.sv - 1R1W synchronous packet RAM with a read-data register that reads 0 after reset
module pck_proc_mem
  import pck_proc_pkg::*;
#(
  parameter int DEPTH  = PCK_DEPTH,
  parameter int ADDR_W = PCK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  mem_word_t         wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output mem_word_t         rdata
);

  mem_word_t mem [DEPTH];
  mem_word_t rd_word_q;
  logic      rd_vld_q, rd_vld_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_word_q <= mem[raddr];
  end

  // The array itself has no reset; this flag masks the read register until the first read.
  always_comb begin
    rd_vld_d = rd_vld_q | re;
    if (!clr_n) rd_vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_q <= 1'b0;
    else        rd_vld_q <= rd_vld_d;
  end

  assign rdata = rd_vld_q ? rd_word_q : '0;

endmodule

// File: rtl/pck_proc_int_mem_fsm.sv
// rtl/pck_proc_int_mem_fsm.sv - store-and-forward packet FIFO with length-checking write FSM
module pck_proc_int_mem_fsm
  import pck_proc_pkg::*;
#(
  parameter int DEPTH  = PCK_DEPTH,
  parameter int ADDR_W = PCK_ADDR_W
) (
  input  logic          pck_proc_int_mem_fsm_clk,
  input  logic          pck_proc_int_mem_fsm_rstn,
  input  logic          pck_proc_int_mem_fsm_sw_rstn,
  input  logic          empty_de_assert,
  input  logic          enq_req,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [31:0]   wr_data_i,
  input  logic          pck_len_valid,
  input  logic [11:0]   pck_len_i,
  input  logic          deq_req,
  output logic          out_sop,
  output logic          out_eop,
  output logic [31:0]   rd_data_o,
  output logic          pck_proc_full,
  output logic          pck_proc_empty,
  input  logic [4:0]    pck_proc_almost_full_value,
  input  logic [4:0]    pck_proc_almost_empty_value,
  output logic          pck_proc_almost_full,
  output logic          pck_proc_almost_empty,
  output logic          pck_proc_overflow,
  output logic          pck_proc_underflow,
  output logic          packet_drop,
  output logic [ADDR_W:0] pck_proc_wr_lvl
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic              clk, sw_rstn;
  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, start_q, start_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     wr_lvl_q, wr_lvl_d, com_lvl_q, com_lvl_d;
  logic [11:0]       cnt_q, cnt_d, len_q, len_d;
  logic              full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, drop_q, drop_d;
  logic              we, re;
  logic [LW-1:0]     free_now, free_post, lvl_inc, rb_amt, commit_amt, rd_dec, len_ext;
  logic [12:0]       cnt_next;
  mem_word_t         wdata, rdata;

  assign clk     = pck_proc_int_mem_fsm_clk;
  assign sw_rstn = pck_proc_int_mem_fsm_sw_rstn;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    start_d    = start_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    we         = 1'b0;
    drop_d     = 1'b0;
    lvl_inc    = '0;
    rb_amt     = '0;
    commit_amt = '0;
    wdata      = '{sop: in_sop, eop: in_eop, data: wr_data_i};
    free_now   = DEPTH_L - wr_lvl_q;
    len_ext    = LW'(pck_len_i);
    cnt_next   = {1'b0, cnt_q} + 13'd1;

    case (state_q)
      ST_IDLE: begin
        if (enq_req && in_sop) begin
          if (!pck_len_valid || pck_len_i == 12'd0 || len_ext > free_now) begin
            drop_d = 1'b1;
          end else if (in_eop && pck_len_i != 12'd1) begin
            // Written-then-rolled-back in the same cycle, so nothing is stored at all.
            drop_d = 1'b1;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            start_d  = wr_ptr_q;
            len_d    = pck_len_i;
            cnt_d    = 12'd1;
            lvl_inc  = LW'(1);
            if (in_eop) commit_amt = LW'(1);
            else        state_d    = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (enq_req) begin
          if (in_sop || (!in_eop && cnt_next > {1'b0, len_q})) begin
            drop_d   = 1'b1;
            wr_ptr_d = start_q;
            rb_amt   = LW'(cnt_q);
            state_d  = ST_DROP;
          end else if (in_eop) begin
            state_d = ST_IDLE;
            if (cnt_next == {1'b0, len_q}) begin
              we         = 1'b1;
              wr_ptr_d   = wr_ptr_q + 1'b1;
              lvl_inc    = LW'(1);
              commit_amt = LW'(len_q);
            end else begin
              drop_d   = 1'b1;
              wr_ptr_d = start_q;
              rb_amt   = LW'(cnt_q);
            end
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            lvl_inc  = LW'(1);
            cnt_d    = cnt_next[11:0];
          end
        end
      end
      ST_DROP: begin
        if (enq_req && in_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reads only ever see committed words, so an in-progress packet is never entered.
    re        = deq_req && (com_lvl_q != '0) && sw_rstn;
    rd_dec    = LW'(re);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(re);
    wr_lvl_d  = wr_lvl_q + lvl_inc - rb_amt - rd_dec;
    com_lvl_d = com_lvl_q + commit_amt - rd_dec;
    free_post = DEPTH_L - wr_lvl_d;
    full_d    = (wr_lvl_d == DEPTH_L);
    empty_d   = ((empty_de_assert ? wr_lvl_d : com_lvl_d) == '0);
    af_d      = (free_post <= LW'(pck_proc_almost_full_value));
    ae_d      = (wr_lvl_d <= LW'(pck_proc_almost_empty_value));
    ovf_d     = enq_req && full_q;
    udf_d     = deq_req && (com_lvl_q == '0);

    if (!sw_rstn) begin
      state_d   = ST_IDLE;
      wr_ptr_d  = '0;
      start_d   = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      len_d     = '0;
      wr_lvl_d  = '0;
      com_lvl_d = '0;
      we        = 1'b0;
      full_d    = 1'b0;
      empty_d   = 1'b1;
      af_d      = 1'b0;
      ae_d      = 1'b1;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      drop_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge pck_proc_int_mem_fsm_rstn) begin
    if (!pck_proc_int_mem_fsm_rstn) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      start_q   <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      wr_lvl_q  <= '0;
      com_lvl_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      start_q   <= start_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_lvl_q  <= wr_lvl_d;
      com_lvl_q <= com_lvl_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      drop_q    <= drop_d;
    end
  end

  pck_proc_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst_n (pck_proc_int_mem_fsm_rstn),
    .clr_n (sw_rstn),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .re    (re),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign out_sop               = rdata.sop;
  assign out_eop               = rdata.eop;
  assign rd_data_o             = rdata.data;
  assign pck_proc_full         = full_q;
  assign pck_proc_empty        = empty_q;
  assign pck_proc_almost_full  = af_q;
  assign pck_proc_almost_empty = ae_q;
  assign pck_proc_overflow     = ovf_q;
  assign pck_proc_underflow    = udf_q;
  assign packet_drop           = drop_q;
  assign pck_proc_wr_lvl       = wr_lvl_q;

endmodule

// File: tb/tb_pck_proc_int_mem_fsm.sv
// tb/tb_pck_proc_int_mem_fsm.sv - directed and randomized checks against a queue-based packet model
module tb_pck_proc_int_mem_fsm;

  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        rstn, sw_rstn, ede, enq_req, in_sop, in_eop, plv, deq_req;
  logic [31:0] wdata;
  logic [11:0] plen;
  logic [4:0]  afv, aev;
  logic        out_sop, out_eop, full, empty, afull, aempty, ovf, udf, pdrop;
  logic [31:0] rd_data;
  logic [13:0] wr_lvl;

  always #5 clk = ~clk;

  pck_proc_int_mem_fsm dut (
    .pck_proc_int_mem_fsm_clk     (clk),
    .pck_proc_int_mem_fsm_rstn    (rstn),
    .pck_proc_int_mem_fsm_sw_rstn (sw_rstn),
    .empty_de_assert              (ede),
    .enq_req                      (enq_req),
    .in_sop                       (in_sop),
    .in_eop                       (in_eop),
    .wr_data_i                    (wdata),
    .pck_len_valid                (plv),
    .pck_len_i                    (plen),
    .deq_req                      (deq_req),
    .out_sop                      (out_sop),
    .out_eop                      (out_eop),
    .rd_data_o                    (rd_data),
    .pck_proc_full                (full),
    .pck_proc_empty               (empty),
    .pck_proc_almost_full_value   (afv),
    .pck_proc_almost_empty_value  (aev),
    .pck_proc_almost_full         (afull),
    .pck_proc_almost_empty        (aempty),
    .pck_proc_overflow            (ovf),
    .pck_proc_underflow           (udf),
    .packet_drop                  (pdrop),
    .pck_proc_wr_lvl              (wr_lvl)
  );

  int n_err = 0;
  int n_chk = 0;

  // Model: committed packets waiting for the reader, the packet being received, and a receive mode.
  logic [33:0] cq[$];
  logic [33:0] pq[$];
  int          mode;   // 0 between packets, 1 receiving, 2 discarding until eop
  int          m_len;
  logic [33:0] exp_rd;
  logic        exp_ovf, exp_udf, exp_drop;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    pq.delete();
    mode     = 0;
    m_len    = 0;
    exp_rd   = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    exp_drop = 1'b0;
  endtask

  task automatic model_step();
    int lvl;
    int free;
    logic [33:0] w;
    lvl  = cq.size() + pq.size();
    free = DEPTH - lvl;
    w    = {in_sop, in_eop, wdata};
    if (!sw_rstn) begin
      model_reset();
      return;
    end
    exp_udf  = deq_req && (cq.size() == 0);
    exp_ovf  = enq_req && (lvl == DEPTH);
    exp_drop = 1'b0;
    if (deq_req && cq.size() > 0) exp_rd = cq.pop_front();
    if (enq_req) begin
      if (mode == 0) begin
        if (in_sop) begin
          if (!plv || plen == 0 || int'(plen) > free) exp_drop = 1'b1;
          else if (in_eop) begin
            if (plen == 1) cq.push_back(w);
            else exp_drop = 1'b1;
          end else begin
            pq.push_back(w);
            m_len = int'(plen);
            mode  = 1;
          end
        end
      end else if (mode == 1) begin
        if (in_sop) begin
          pq.delete(); exp_drop = 1'b1; mode = 2;
        end else if (in_eop) begin
          if (pq.size() + 1 == m_len) begin
            pq.push_back(w);
            foreach (pq[i]) cq.push_back(pq[i]);
          end else exp_drop = 1'b1;
          pq.delete();
          mode = 0;
        end else if (pq.size() + 1 > m_len) begin
          pq.delete(); exp_drop = 1'b1; mode = 2;
        end else pq.push_back(w);
      end else if (in_eop) mode = 0;
    end
  endtask

  task automatic check_all(string t);
    int lvl;
    int cs;
    lvl = cq.size() + pq.size();
    cs  = cq.size();
    chk({t, ".rd"},     {out_sop, out_eop, rd_data}, exp_rd);
    chk({t, ".lvl"},    wr_lvl, lvl);
    chk({t, ".full"},   full, lvl == DEPTH);
    chk({t, ".empty"},  empty, (ede ? lvl : cs) == 0);
    chk({t, ".afull"},  afull, (DEPTH - lvl) <= int'(afv));
    chk({t, ".aempty"}, aempty, lvl <= int'(aev));
    chk({t, ".ovf"},    ovf, exp_ovf);
    chk({t, ".udf"},    udf, exp_udf);
    chk({t, ".drop"},   pdrop, exp_drop);
  endtask

  task automatic step(string t, bit e, bit s, bit eo, logic [31:0] d, bit v, logic [11:0] l, bit q);
    enq_req = e; in_sop = s; in_eop = eo; wdata = d; plv = v; plen = l; deq_req = q;
    model_step();
    @(posedge clk);
    #1;
    check_all(t);
  endtask

  task automatic send_pkt(string t, int nw, int len, bit v, bit with_eop, int gap, int dq_pct);
    for (int i = 0; i < nw; i++) begin
      for (int g = 0; g < gap; g++)
        step(t, 0, 0, 0, 0, 0, 0, $urandom_range(99) < dq_pct);
      step(t, 1, i == 0, with_eop && (i == nw - 1), $urandom, v, 12'(len),
           $urandom_range(99) < dq_pct);
    end
  endtask

  initial begin
    rstn = 1'b0; sw_rstn = 1'b1; ede = 1'b0; afv = 5'd2; aev = 5'd1;
    enq_req = 0; in_sop = 0; in_eop = 0; wdata = 0; plv = 0; plen = 0; deq_req = 0;
    model_reset();
    #12;
    check_all("reset");
    rstn = 1'b1;
    step("idle", 0, 0, 0, 0, 0, 0, 0);

    // Single 4-word packet, then drain it
    send_pkt("pkt4", 4, 4, 1, 1, 0, 0);
    chk("pkt4.lvl4", wr_lvl, 4);
    step("deq1", 0, 0, 0, 0, 0, 0, 1);
    chk("deq1.sop", out_sop, 1);
    step("deq2", 0, 0, 0, 0, 0, 0, 1);
    step("deq3", 0, 0, 0, 0, 0, 0, 1);
    step("deq4", 0, 0, 0, 0, 0, 0, 1);
    chk("deq4.eop", out_eop, 1);
    chk("deq4.empty", empty, 1);

    // Short packet: eop on word 3 of a declared 4
    send_pkt("short", 3, 4, 1, 1, 0, 0);
    chk("short.drop", pdrop, 1);
    chk("short.lvl", wr_lvl, 0);
    step("udf", 0, 0, 0, 0, 0, 0, 1);
    chk("udf.pulse", udf, 1);

    // Fill to 8190 words, then a packet that does not fit
    send_pkt("fill_a", 4095, 4095, 1, 1, 0, 0);
    send_pkt("fill_b", 4095, 4095, 1, 1, 0, 0);
    step("nofit", 1, 1, 0, 32'h1234, 1, 12'd4, 0);
    chk("nofit.drop", pdrop, 1);
    chk("nofit.lvl", wr_lvl, 8190);
    chk("nofit.afull", afull, 1);
    step("nofit_w", 1, 0, 0, 32'h5678, 0, 0, 0);
    step("nofit_e", 1, 0, 1, 32'h9abc, 0, 0, 0);
    rstn = 1'b0;
    model_reset();
    #2;
    check_all("hard_rst");
    rstn = 1'b1;

    // empty_de_assert selects total vs committed level
    ede = 1'b1;
    step("ede_w1", 1, 1, 0, 32'hA1, 1, 12'd3, 0);
    chk("ede1.empty", empty, 0);
    ede = 1'b0;
    step("ede_w2", 1, 0, 0, 32'hA2, 0, 0, 0);
    chk("ede0.empty", empty, 1);
    step("ede_w3", 1, 0, 1, 32'hA3, 0, 0, 0);
    chk("ede0.commit", empty, 0);
    for (int i = 0; i < 3; i++) step("ede_drain", 0, 0, 0, 0, 0, 0, 1);

    // Soft reset mid-packet
    send_pkt("sw_pre", 2, 4, 1, 0, 0, 0);
    sw_rstn = 1'b0;
    step("sw_rst", 0, 0, 0, 0, 0, 0, 0);
    chk("sw_rst.lvl", wr_lvl, 0);
    sw_rstn = 1'b1;
    send_pkt("sw_post", 2, 2, 1, 1, 0, 0);
    chk("sw_post.lvl", wr_lvl, 2);
    step("sw_d1", 0, 0, 0, 0, 0, 0, 1);
    step("sw_d2", 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with malformed, unvalidated and truncated packets
    for (int p = 0; p < 300; p++) begin
      int len;
      int nw;
      int r;
      ede = 1'($urandom);
      afv = 5'($urandom);
      aev = 5'($urandom);
      len = $urandom_range(0, 8);
      r   = $urandom_range(9);
      nw  = (len == 0) ? 1 : len;
      if (r == 0) nw = nw + 1;
      else if (r == 1 && nw > 1) nw = nw - 1;
      send_pkt("rnd", nw, len, $urandom_range(9) != 0, $urandom_range(9) != 0,
               $urandom_range(0, 2), 45);
    end
    for (int i = 0; i < 400 && cq.size() > 0; i++) step("drain", 0, 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
